// File: rtl/eu_pkg.sv
// Shared definitions for the eu_logic arbiter slice.
// Holds the logic-unit op codes, the arbiter FSM state encoding and a
// helper that tells whether an op code is one the logic unit implements.
package eu_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_logic_op(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   req0, req1  : request lines
//   last_grant  : index of the requester granted most recently
//   grant       : one-hot grant, bit N for requester N (all zero if no request)
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On conflict, the requester that was not granted last time wins.
    assign grant[0] = req0 & (~req1 | last_grant);
    assign grant[1] = req1 & (~req0 | ~last_grant);

endmodule

// File: rtl/eu_logic_arbiter.sv
// Shares one external combinational eu_logic unit between two requesters.
// One micro-op is accepted at a time (round-robin on conflict), its
// operands/op code are driven to the unit from registers for one cycle,
// the unit's result is captured, and it is returned on the owner's
// valid/ready response channel.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b          : request channel of requester N
//   rspN_valid/ready/data/err        : response channel of requester N
//   eu_a, eu_b, eu_op_select         : registered drive to eu_logic
//   eu_data_out                      : eu_logic result
//   busy                             : an operation is in flight
module eu_logic_arbiter
    import eu_pkg::*;
#(
    parameter int BUS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [3:0]           req0_op,
    input  logic [BUS_WIDTH-1:0] req0_a,
    input  logic [BUS_WIDTH-1:0] req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [3:0]           req1_op,
    input  logic [BUS_WIDTH-1:0] req1_a,
    input  logic [BUS_WIDTH-1:0] req1_b,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [BUS_WIDTH-1:0] rsp0_data,
    output logic                 rsp0_err,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [BUS_WIDTH-1:0] rsp1_data,
    output logic                 rsp1_err,
    output logic [BUS_WIDTH-1:0] eu_a,
    output logic [BUS_WIDTH-1:0] eu_b,
    output logic [3:0]           eu_op_select,
    input  logic [BUS_WIDTH-1:0] eu_data_out,
    output logic                 busy
);

    state_t               state_reg;
    logic                 owner_reg;
    logic                 last_grant_reg;
    logic [BUS_WIDTH-1:0] eu_a_reg;
    logic [BUS_WIDTH-1:0] eu_b_reg;
    logic [3:0]           eu_op_reg;
    logic [1:0]           rsp_valid_reg;
    logic [1:0]           rsp_err_reg;
    logic [BUS_WIDTH-1:0] rsp_data_reg [2];

    logic [1:0]           grant;
    logic [1:0]           rsp_ready_vec;

    rr_arb2 u_arb (
        .req0       (req0_valid),
        .req1       (req1_valid),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    // Grants are only offered while idle; the arbiter already gates on valid.
    assign req0_ready    = (state_reg == IDLE) & grant[0];
    assign req1_ready    = (state_reg == IDLE) & grant[1];
    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            owner_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            eu_a_reg        <= '0;
            eu_b_reg        <= '0;
            eu_op_reg       <= OP_NOP;
            rsp_valid_reg   <= 2'b00;
            rsp_err_reg     <= 2'b00;
            rsp_data_reg[0] <= '0;
            rsp_data_reg[1] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        owner_reg      <= req1_ready;
                        last_grant_reg <= req1_ready;
                        eu_a_reg       <= req1_ready ? req1_a  : req0_a;
                        eu_b_reg       <= req1_ready ? req1_b  : req0_b;
                        eu_op_reg      <= req1_ready ? req1_op : req0_op;
                        state_reg      <= EXEC;
                    end else begin
                        eu_op_reg <= OP_NOP;
                    end
                end
                EXEC: begin
                    // Illegal codes never forward whatever the unit produced.
                    rsp_valid_reg[owner_reg] <= 1'b1;
                    rsp_err_reg[owner_reg]   <= ~is_logic_op(eu_op_reg);
                    rsp_data_reg[owner_reg]  <= is_logic_op(eu_op_reg) ? eu_data_out : '0;
                    state_reg                <= RESP;
                end
                RESP: begin
                    // Only the owner's ready can retire the response.
                    if (rsp_ready_vec[owner_reg]) begin
                        rsp_valid_reg[owner_reg] <= 1'b0;
                        eu_op_reg                <= OP_NOP;
                        state_reg                <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign eu_a         = eu_a_reg;
    assign eu_b         = eu_b_reg;
    assign eu_op_select = eu_op_reg;
    assign rsp0_valid   = rsp_valid_reg[0];
    assign rsp1_valid   = rsp_valid_reg[1];
    assign rsp0_err     = rsp_err_reg[0];
    assign rsp1_err     = rsp_err_reg[1];
    assign rsp0_data    = rsp_data_reg[0];
    assign rsp1_data    = rsp_data_reg[1];
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_eu_logic_arbiter.sv
module tb_eu_logic_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = 0, req1_op = 0;
    logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic        rsp0_ready = 0, rsp1_ready = 0;
    logic [15:0] rsp0_data, rsp1_data;
    logic [15:0] eu_a, eu_b, eu_data_out;
    logic [3:0]  eu_op_select;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eu_logic_arbiter #(.BUS_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .eu_a(eu_a), .eu_b(eu_b), .eu_op_select(eu_op_select), .eu_data_out(eu_data_out), .busy(busy)
    );

    // Stand-in for the external eu_logic; illegal codes give garbage on purpose.
    function automatic logic [15:0] eu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'b1000: return a & b;
            4'b1001: return a | b;
            4'b1010: return a ^ b;
            4'b1011: return ~a;
            default: return a ^ b ^ 16'h5a5a;
        endcase
    endfunction

    assign eu_data_out = eu_f(eu_op_select, eu_a, eu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: transaction age (0 free, 1 just accepted, 2 awaiting
    // consumer), owner, last winner, and the values each output must show.
    int          m_age = 0;
    int          m_owner = 0;
    int          m_last = 1;
    logic [15:0] m_a = 0, m_b = 0;
    logic [3:0]  m_op = 0;
    logic [15:0] m_data [2];
    logic        m_err [2];
    int          grant_q[$];
    int          resp_who_q[$];
    logic [15:0] resp_data_q[$];
    logic        resp_err_q[$];

    initial begin
        m_data[0] = 0; m_data[1] = 0; m_err[0] = 0; m_err[1] = 0;
    end

    always @(negedge clk) begin
        logic e_r0, e_r1;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            chk("rst_eu_op", eu_op_select, 0);
            chk("rst_eu_ab", {eu_a, eu_b}, 0);
            chk("rst_rsp_data", {rsp0_data, rsp1_data}, 0);
            chk("rst_rsp_err", {rsp0_err, rsp1_err}, 0);
            m_age = 0; m_last = 1; m_a = 0; m_b = 0; m_op = 0;
            m_data[0] = 0; m_data[1] = 0; m_err[0] = 0; m_err[1] = 0;
        end else begin
            e_r0 = 0; e_r1 = 0;
            if (m_age == 0) begin
                e_r0 = req0_valid && (!req1_valid || m_last == 1);
                e_r1 = req1_valid && (!req0_valid || m_last == 0);
            end
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("busy", busy, m_age != 0);
            chk("eu_a", eu_a, m_a);
            chk("eu_b", eu_b, m_b);
            chk("eu_op", eu_op_select, m_op);
            chk("rsp0_valid", rsp0_valid, m_age == 2 && m_owner == 0);
            chk("rsp1_valid", rsp1_valid, m_age == 2 && m_owner == 1);
            chk("rsp0_data", rsp0_data, m_data[0]);
            chk("rsp1_data", rsp1_data, m_data[1]);
            chk("rsp0_err", rsp0_err, m_err[0]);
            chk("rsp1_err", rsp1_err, m_err[1]);
            // DUT-side logs for the directed literal checks
            if (req0_valid && req0_ready) grant_q.push_back(0);
            if (req1_valid && req1_ready) grant_q.push_back(1);
            if (rsp0_valid && rsp0_ready) begin
                resp_who_q.push_back(0); resp_data_q.push_back(rsp0_data); resp_err_q.push_back(rsp0_err);
            end
            if (rsp1_valid && rsp1_ready) begin
                resp_who_q.push_back(1); resp_data_q.push_back(rsp1_data); resp_err_q.push_back(rsp1_err);
            end
            // advance the model to what the coming edge must produce
            if (m_age == 0) begin
                if (e_r0 || e_r1) begin
                    m_owner = e_r1 ? 1 : 0;
                    m_last  = m_owner;
                    m_a  = e_r1 ? req1_a  : req0_a;
                    m_b  = e_r1 ? req1_b  : req0_b;
                    m_op = e_r1 ? req1_op : req0_op;
                    m_age = 1;
                end else begin
                    m_op = 0;
                end
            end else if (m_age == 1) begin
                if (m_op >= 4'b1000 && m_op <= 4'b1011) begin
                    m_data[m_owner] = eu_f(m_op, m_a, m_b);
                    m_err[m_owner]  = 0;
                end else begin
                    m_data[m_owner] = 0;
                    m_err[m_owner]  = 1;
                end
                m_age = 2;
            end else begin
                if ((m_owner == 0 && rsp0_ready) || (m_owner == 1 && rsp1_ready)) begin
                    m_age = 0;
                    m_op  = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int who, input string name);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((who == 0 && req0_valid && req0_ready) || (who == 1 && req1_valid && req1_ready)) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_rsp(input int who, input string name);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((who == 0 && rsp0_valid) || (who == 1 && rsp1_valid)) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
    endtask

    initial begin
        int g0, r0, rc;
        // reset state
        tick();
        @(negedge clk);
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_eu", {eu_op_select, eu_a, eu_b}, 0);
        chk("lit_rst_valids", {rsp0_valid, rsp1_valid}, 0);
        do_reset();

        // single request: AND cafe & cafe
        req0_valid = 1; req0_op = 4'b1000; req0_a = 16'hcafe; req0_b = 16'hcafe;
        rsp0_ready = 1; rsp1_ready = 1;
        @(negedge clk);
        chk("lit_single_ready_N", req0_ready, 1);
        tick();
        req0_valid = 0;
        @(negedge clk);
        chk("lit_single_N1_valid", rsp0_valid, 0);
        @(negedge clk);
        chk("lit_single_N2_valid", rsp0_valid, 1);
        chk("lit_single_data", rsp0_data, 16'hcafe);
        chk("lit_single_err", rsp0_err, 0);
        chk("lit_single_rsp1", rsp1_valid, 0);
        tick();

        // contention from reset, four back-to-back pairs
        rst_n = 0;
        req0_valid = 1; req0_op = 4'b1001; req0_a = 16'h0000; req0_b = 16'h0010;
        req1_valid = 1; req1_op = 4'b1010; req1_a = 16'h0000; req1_b = 16'h1000;
        repeat (2) tick();
        g0 = grant_q.size(); r0 = resp_who_q.size();
        rst_n = 1;
        for (int i = 0; i < 100 && grant_q.size() < g0 + 8; i++) tick();
        req0_valid = 0; req1_valid = 0;
        repeat (4) tick();
        chk("lit_cont_count", grant_q.size() - g0, 8);
        for (int i = 0; i < 8 && g0 + i < grant_q.size(); i++) chk("lit_cont_order", grant_q[g0+i], i % 2);
        chk("lit_cont_first_who", resp_who_q[r0], 0);
        chk("lit_cont_first_data", resp_data_q[r0], 16'h0010);
        chk("lit_cont_second_who", resp_who_q[r0+1], 1);
        chk("lit_cont_second_data", resp_data_q[r0+1], 16'h1000);

        // backpressure: req1 NOT ff11 held 5 cycles, req0 waits
        rsp1_ready = 0;
        req1_valid = 1; req1_op = 4'b1011; req1_a = 16'hff11; req1_b = 16'h1234;
        wait_hs(1, "lit_bp_hs");
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_op = 4'b1000; req0_a = 16'h0f0f; req0_b = 16'hffff;
        @(negedge clk);
        chk("lit_bp_exec_req0_ready", req0_ready, 0);
        repeat (5) begin
            @(negedge clk);
            chk("lit_bp_valid", rsp1_valid, 1);
            chk("lit_bp_data", rsp1_data, 16'h00ee);
            chk("lit_bp_req0_ready", req0_ready, 0);
        end
        @(posedge clk); #1;
        rsp1_ready = 1;
        @(negedge clk);
        chk("lit_bp_release_cycle", req0_ready, 0);
        @(negedge clk);
        chk("lit_bp_after_release", req0_ready, 1);
        tick();
        req0_valid = 0;
        repeat (3) tick();

        // illegal op then a legal one
        req0_valid = 1; req0_op = 4'b0011; req0_a = 16'h1234; req0_b = 16'h5555;
        wait_hs(0, "lit_ill_hs");
        tick();
        req0_valid = 0;
        wait_rsp(0, "lit_ill_rsp");
        chk("lit_ill_err", rsp0_err, 1);
        chk("lit_ill_data", rsp0_data, 16'h0000);
        tick();
        req0_valid = 1; req0_op = 4'b1001; req0_a = 16'h00f0; req0_b = 16'h0f00;
        wait_hs(0, "lit_post_ill_hs");
        tick();
        req0_valid = 0;
        wait_rsp(0, "lit_post_ill_rsp");
        chk("lit_post_ill_data", rsp0_data, 16'h0ff0);
        chk("lit_post_ill_err", rsp0_err, 0);
        tick();

        // reset during EXEC
        rc = resp_who_q.size();
        req0_valid = 1; req0_op = 4'b1010; req0_a = 16'haaaa; req0_b = 16'h5555;
        wait_hs(0, "lit_mid_hs");
        tick();
        rst_n = 0;
        req0_valid = 0;
        @(negedge clk);
        chk("lit_mid_busy", busy, 0);
        chk("lit_mid_rsp0", rsp0_valid, 0);
        tick();
        rst_n = 1;
        repeat (4) tick();
        chk("lit_mid_no_resp", resp_who_q.size(), rc);
        req1_valid = 1; req1_op = 4'b1000; req1_a = 16'h0001; req1_b = 16'h0000;
        wait_hs(1, "lit_mid_new_hs");
        tick();
        req1_valid = 0;
        wait_rsp(1, "lit_mid_new_rsp");
        chk("lit_mid_new_data", rsp1_data, 16'h0000);
        chk("lit_mid_new_err", rsp1_err, 0);
        tick();

        // randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 600; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_op = ($urandom_range(0, 3) != 0) ? {2'b10, 2'($urandom_range(0, 3))} : 4'($urandom_range(0, 15));
            req1_op = ($urandom_range(0, 3) != 0) ? {2'b10, 2'($urandom_range(0, 3))} : 4'($urandom_range(0, 15));
            req0_a = 16'($urandom); req0_b = 16'($urandom);
            req1_a = 16'($urandom); req1_b = 16'($urandom);
            rsp0_ready = ($urandom_range(0, 1) != 0);
            rsp1_ready = ($urandom_range(0, 1) != 0);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
